conv_encoder_stream: RTL and testbench

//  Parametrised rate-1/2 feed-forward convolutional encoder with valid/ready streaming and frame

---
 rtl/conv_enc_pkg.sv | 19 +
 rtl/conv_enc_step.sv | 44 ++++
 rtl/conv_encoder_stream.sv | 126 ++++++++++++
 tb/tb_conv_encoder_stream.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_enc_pkg.sv
// Shared definitions for the streaming rate-1/2 convolutional encoder:
// default generator polynomials, FSM encoding and a parity helper.
package conv_enc_pkg;

    localparam logic [2:0] CONV_G0_K3 = 3'o7;
    localparam logic [2:0] CONV_G1_K3 = 3'o5;
    localparam logic [6:0] CONV_G0_K7 = 7'o171;
    localparam logic [6:0] CONV_G1_K7 = 7'o133;

    typedef enum logic {
        S_DATA,
        S_TAIL
    } fsm_t;

    function automatic logic parity(input logic [31:0] v);
        return ^v;
    endfunction

endpackage

// File: rtl/conv_enc_step.sv
// Combinational unrolled encoder: processes the first nbits info bits (MSB first)
// from the given shift state; unused coded LSB pairs are zero.
module conv_enc_step
    import conv_enc_pkg::*;
#(
    parameter int              DATA_W = 8,
    parameter int              K      = 3,
    parameter logic [K-1:0]    G0     = CONV_G0_K3,
    parameter logic [K-1:0]    G1     = CONV_G1_K3
) (
    input  logic [DATA_W-1:0]          info,
    input  logic [K-2:0]               state,
    input  logic [$clog2(DATA_W+1)-1:0] nbits,
    output logic [2*DATA_W-1:0]        coded,
    output logic [K-2:0]               state_next
);

    localparam int NB_W = $clog2(DATA_W + 1);

    // chain[i] is the shift state seen by info bit i (bit 0 = oldest history bit)
    logic [DATA_W:0][K-2:0] chain;

    assign chain[0] = state;

    genvar gi;
    generate
        for (gi = 0; gi < DATA_W; gi++) begin : g_bit
            logic         u;
            logic         active;
            logic [K-1:0] w;

            assign u      = info[DATA_W-1-gi];
            assign active = NB_W'(gi) < nbits;
            assign w      = {u, chain[gi]};

            assign chain[gi+1] = active ? {u, chain[gi][K-2:1]} : chain[gi];
            assign coded[2*DATA_W-1-2*gi -: 2] =
                active ? {parity(32'(w & G0)), parity(32'(w & G1))} : 2'b00;
        end
    endgenerate

    assign state_next = chain[DATA_W];

endmodule

// File: rtl/conv_encoder_stream.sv
// Streaming rate-1/2 convolutional encoder with a single output register stage
// and optional zero-tail flush beat at the end of each frame.
module conv_encoder_stream
    import conv_enc_pkg::*;
#(
    parameter int           DATA_W  = 8,
    parameter int           K       = 3,
    parameter logic [K-1:0] G0      = CONV_G0_K3,
    parameter logic [K-1:0] G1      = CONV_G1_K3,
    parameter bit           TAIL_EN = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_W-1:0]     in_data,
    input  logic                  in_valid,
    input  logic                  in_last,
    output logic                  in_ready,
    output logic [2*DATA_W-1:0]   out_data,
    output logic                  out_valid,
    output logic                  out_tail,
    output logic                  out_last,
    input  logic                  out_ready
);

    localparam int NB_W = $clog2(DATA_W + 1);

    fsm_t                  fsm_reg, fsm_next;
    logic [K-2:0]          shift_reg, shift_next;
    logic [2*DATA_W-1:0]   out_data_reg, out_data_next;
    logic                  out_valid_reg, out_valid_next;
    logic                  out_tail_reg, out_tail_next;
    logic                  out_last_reg, out_last_next;

    logic                  slot_free;
    logic                  accept;
    logic [DATA_W-1:0]     step_info;
    logic [NB_W-1:0]       step_nbits;
    logic [2*DATA_W-1:0]   step_coded;
    logic [K-2:0]          step_state;

    assign slot_free = !out_valid_reg || out_ready;
    assign in_ready  = !reset && (fsm_reg == S_DATA) && slot_free;
    assign accept    = in_valid && in_ready;

    // The single step instance is shared: the tail beat is K-1 zero info bits
    assign step_info  = (fsm_reg == S_TAIL) ? '0 : in_data;
    assign step_nbits = (fsm_reg == S_TAIL) ? NB_W'(K - 1) : NB_W'(DATA_W);

    conv_enc_step #(
        .DATA_W (DATA_W),
        .K      (K),
        .G0     (G0),
        .G1     (G1)
    ) u_step (
        .info       (step_info),
        .state      (shift_reg),
        .nbits      (step_nbits),
        .coded      (step_coded),
        .state_next (step_state)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            fsm_reg       <= S_DATA;
            shift_reg     <= '0;
            out_data_reg  <= '0;
            out_valid_reg <= 1'b0;
            out_tail_reg  <= 1'b0;
            out_last_reg  <= 1'b0;
        end else begin
            fsm_reg       <= fsm_next;
            shift_reg     <= shift_next;
            out_data_reg  <= out_data_next;
            out_valid_reg <= out_valid_next;
            out_tail_reg  <= out_tail_next;
            out_last_reg  <= out_last_next;
        end
    end

    always_comb begin
        fsm_next       = fsm_reg;
        shift_next     = shift_reg;
        out_data_next  = out_data_reg;
        out_valid_next = out_valid_reg;
        out_tail_next  = out_tail_reg;
        out_last_next  = out_last_reg;

        case (fsm_reg)
            S_DATA: begin
                if (accept) begin
                    out_data_next  = step_coded;
                    out_valid_next = 1'b1;
                    out_tail_next  = 1'b0;
                    out_last_next  = in_last && !TAIL_EN;
                    shift_next     = step_state;
                    if (in_last) begin
                        if (TAIL_EN) begin
                            fsm_next = S_TAIL;
                        end else begin
                            shift_next = '0;
                        end
                    end
                end else if (out_ready) begin
                    out_valid_next = 1'b0;
                end
            end
            S_TAIL: begin
                if (slot_free) begin
                    out_data_next  = step_coded;
                    out_valid_next = 1'b1;
                    out_tail_next  = 1'b1;
                    out_last_next  = 1'b1;
                    shift_next     = '0;
                    fsm_next       = S_DATA;
                end
            end
            default: fsm_next = S_DATA;
        endcase
    end

    assign out_data  = out_data_reg;
    assign out_valid = out_valid_reg;
    assign out_tail  = out_tail_reg;
    assign out_last  = out_last_reg;

endmodule

// File: tb/tb_conv_encoder_stream.sv
// Self-checking bench: directed frames plus random traffic against a bit-level
// convolution reference model; one DUT with tail flush, one without.
module tb_conv_encoder_stream;

    localparam int K = 3;

    typedef struct {
        logic [15:0] data;
        logic        tail;
        logic        last;
    } beat_t;

    typedef struct {
        logic [7:0] d;
        logic       last;
    } tx_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [7:0]  in_data = '0;
    logic        iv = 1'b0;
    logic        in_last = 1'b0;
    logic        out_ready = 1'b1;
    int          sel = 0;

    logic        iv0, iv1;
    logic        ir0, ir1, ov0, ov1, ot0, ot1, ol0, ol1;
    logic [15:0] od0, od1;

    int          checks = 0;
    int          errors = 0;

    logic [2:0]  g0v = 3'o7;
    logic [2:0]  g1v = 3'o5;

    bit          hist[$];
    beat_t       exp_q[$];
    beat_t       got_q[$];
    tx_t         tx_q[$];
    bit          chk_rdy = 0;

    always #5 clk = ~clk;

    assign iv0 = iv && (sel == 0);
    assign iv1 = iv && (sel == 1);

    conv_encoder_stream #(.DATA_W(8), .K(3), .G0(3'o7), .G1(3'o5), .TAIL_EN(1'b1)) dut (
        .clk(clk), .reset(reset), .in_data(in_data), .in_valid(iv0), .in_last(in_last),
        .in_ready(ir0), .out_data(od0), .out_valid(ov0), .out_tail(ot0), .out_last(ol0),
        .out_ready(out_ready)
    );

    conv_encoder_stream #(.DATA_W(8), .K(3), .G0(3'o7), .G1(3'o5), .TAIL_EN(1'b0)) dut_nt (
        .clk(clk), .reset(reset), .in_data(in_data), .in_valid(iv1), .in_last(in_last),
        .in_ready(ir1), .out_data(od1), .out_valid(ov1), .out_tail(ot1), .out_last(ol1),
        .out_ready(out_ready)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // Coded pair for info bit index t of the current frame: plain convolution sum
    function automatic logic [1:0] pair_at(int t);
        logic c0 = 1'b0;
        logic c1 = 1'b0;
        for (int j = 0; j < K; j++) begin
            if (t - j >= 0) begin
                c0 ^= g0v[K-1-j] & hist[t-j];
                c1 ^= g1v[K-1-j] & hist[t-j];
            end
        end
        return {c0, c1};
    endfunction

    task automatic model_accept(input logic [7:0] d, input logic last, input bit tail_en);
        beat_t b;
        beat_t tb;
        b.data = '0;
        for (int i = 0; i < 8; i++) begin
            hist.push_back(d[7-i]);
            b.data[15-2*i -: 2] = pair_at(hist.size() - 1);
        end
        b.tail = 1'b0;
        b.last = last && !tail_en;
        exp_q.push_back(b);
        if (last) begin
            if (tail_en) begin
                tb.data = '0;
                for (int i = 0; i < K - 1; i++) begin
                    hist.push_back(1'b0);
                    tb.data[15-2*i -: 2] = pair_at(hist.size() - 1);
                end
                tb.tail = 1'b1;
                tb.last = 1'b1;
                exp_q.push_back(tb);
            end
            hist.delete();
        end
    endtask

    // Inputs are already driven; sample, check, model the edge, advance one cycle
    task automatic step_cycle();
        logic        ov, ot, ol, ir;
        logic [15:0] od;
        beat_t       f;
        #1;
        ov = (sel == 1) ? ov1 : ov0;
        ot = (sel == 1) ? ot1 : ot0;
        ol = (sel == 1) ? ol1 : ol0;
        ir = (sel == 1) ? ir1 : ir0;
        od = (sel == 1) ? od1 : od0;
        chk("out_valid", 32'(ov), 32'(exp_q.size() != 0));
        if (ov && exp_q.size() != 0) begin
            f = exp_q[0];
            chk("out_data", 32'(od), 32'(f.data));
            chk("out_tail", 32'(ot), 32'(f.tail));
            chk("out_last", 32'(ol), 32'(f.last));
            if (out_ready) begin
                got_q.push_back(f);
                void'(exp_q.pop_front());
            end
        end
        if (chk_rdy)
            chk("in_ready", 32'(ir), 32'(!(ov && !out_ready)));
        if (iv && ir) begin
            model_accept(in_data, in_last, sel == 0);
            void'(tx_q.pop_front());
        end
        @(posedge clk);
        #1;
    endtask

    task automatic run(input int rmode, input bit rand_valid, input int budget);
        int cyc = 0;
        while ((tx_q.size() != 0 || exp_q.size() != 0) && cyc < budget) begin
            if (tx_q.size() != 0 && (!rand_valid || $urandom_range(0, 2) != 0)) begin
                iv      = 1'b1;
                in_data = tx_q[0].d;
                in_last = tx_q[0].last;
            end else begin
                iv      = 1'b0;
                in_data = 8'($urandom);
                in_last = 1'($urandom);
            end
            case (rmode)
                0:       out_ready = 1'b1;
                1:       out_ready = (cyc % 3 == 0);
                default: out_ready = ($urandom_range(0, 3) != 0);
            endcase
            step_cycle();
            cyc++;
        end
        iv = 1'b0;
        out_ready = 1'b1;
        chk("drained", 32'(tx_q.size() + exp_q.size()), 32'd0);
    endtask

    task automatic do_reset();
        logic ir;
        reset = 1'b1;
        iv    = 1'b0;
        #1;
        ir = (sel == 1) ? ir1 : ir0;
        chk("rst_in_ready", 32'(ir), 32'd0);
        @(posedge clk);
        #1;
        chk("rst_out_valid", 32'((sel == 1) ? ov1 : ov0), 32'd0);
        chk("rst_out_data", 32'((sel == 1) ? od1 : od0), 32'd0);
        chk("rst_out_tail", 32'((sel == 1) ? ot1 : ot0), 32'd0);
        chk("rst_out_last", 32'((sel == 1) ? ol1 : ol0), 32'd0);
        reset = 1'b0;
        hist.delete();
        exp_q.delete();
        got_q.delete();
    endtask

    task automatic push_tx(input logic [7:0] d, input logic last);
        tx_t t;
        t.d = d;
        t.last = last;
        tx_q.push_back(t);
    endtask

    task automatic chk_got(input string tag, input int idx, input logic [15:0] d,
                           input logic tail, input logic last);
        chk({tag, "_present"}, 32'(got_q.size() > idx), 32'd1);
        if (got_q.size() > idx) begin
            chk({tag, "_data"}, 32'(got_q[idx].data), 32'(d));
            chk({tag, "_tail"}, 32'(got_q[idx].tail), 32'(tail));
            chk({tag, "_last"}, 32'(got_q[idx].last), 32'(last));
        end
    endtask

    initial begin
        @(posedge clk);
        #1;
        sel = 0;
        do_reset();

        // Single frame 0xAA with tail
        push_tx(8'hAA, 1'b1);
        run(0, 1'b0, 50);
        chk_got("t1_b0", 0, 16'hE222, 1'b0, 1'b0);
        chk_got("t1_b1", 1, 16'hC000, 1'b1, 1'b1);

        // Two back-to-back 0xFF frames, second restarts from zero state
        got_q.delete();
        push_tx(8'hFF, 1'b1);
        push_tx(8'hFF, 1'b1);
        run(0, 1'b0, 50);
        chk_got("t2_b0", 0, 16'hDAAA, 1'b0, 1'b0);
        chk_got("t2_b1", 1, 16'h7000, 1'b1, 1'b1);
        chk_got("t2_b2", 2, 16'hDAAA, 1'b0, 1'b0);
        chk_got("t2_b3", 3, 16'h7000, 1'b1, 1'b1);

        // Stalled stream of 4 beats, ready pattern 1,0,0,...
        got_q.delete();
        chk_rdy = 1;
        for (int i = 0; i < 4; i++) push_tx(8'($urandom), 1'b0);
        run(1, 1'b0, 100);
        chk_rdy = 0;
        chk("t3_count", 32'(got_q.size()), 32'd4);
        push_tx(8'($urandom), 1'b1);
        run(0, 1'b0, 50);

        // State carries across beats within a frame
        got_q.delete();
        push_tx(8'hAA, 1'b0);
        push_tx(8'h00, 1'b1);
        run(0, 1'b0, 50);
        chk_got("t4_b1", 1, 16'hC000, 1'b0, 1'b0);
        chk_got("t4_b2", 2, 16'h0000, 1'b1, 1'b1);

        // Reset mid-frame drops the frame with no tail
        iv = 1'b1; in_data = 8'hAA; in_last = 1'b0; out_ready = 1'b0;
        step_cycle();
        iv = 1'b0;
        step_cycle();
        do_reset();
        out_ready = 1'b1;
        step_cycle();
        push_tx(8'hAA, 1'b1);
        run(0, 1'b0, 50);
        chk_got("t5_b0", 0, 16'hE222, 1'b0, 1'b0);

        // No-tail variant
        sel = 1;
        do_reset();
        push_tx(8'hAA, 1'b1);
        push_tx(8'hAA, 1'b1);
        run(0, 1'b0, 50);
        chk("t6_count", 32'(got_q.size()), 32'd2);
        chk_got("t6_b0", 0, 16'hE222, 1'b0, 1'b1);
        chk_got("t6_b1", 1, 16'hE222, 1'b0, 1'b1);

        // Random frames with random valid gaps and back-pressure on both variants
        for (int s = 0; s < 2; s++) begin
            sel = s;
            do_reset();
            for (int f = 0; f < 20; f++) begin
                int len = $urandom_range(1, 4);
                for (int b = 0; b < len; b++) push_tx(8'($urandom), b == len - 1);
            end
            run(2, 1'b1, 2000);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
